// File: rtl/gsim_x_writer.sv
// rtl/gsim_x_writer.sv - Gauss-Seidel solution writer into the x result memory
// Buffers up to two vectors and streams one element per cycle; pulses done after the last word.
module gsim_x_writer #(
  parameter int N_ELEM = 16,
  parameter int DW     = 32,
  parameter int AW     = 9
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [4:0]           i_matrix_num,
  input  logic                 i_x_vld,
  input  logic [N_ELEM*DW-1:0] i_x_vec,
  output logic                 o_x_rdy,
  output logic                 o_x_wen,
  output logic [AW-1:0]        o_x_addr,
  output logic [DW-1:0]        o_x_data,
  output logic                 o_busy,
  output logic                 o_proc_done
);

  localparam int EW = $clog2(N_ELEM);
  localparam int VW = N_ELEM * DW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    num_q, num_d;
  logic [4:0]    acc_cnt_q, acc_cnt_d;
  logic [4:0]    wr_mtx_q, wr_mtx_d;
  logic [EW-1:0] elem_q, elem_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic          wr_ptr_q, rd_ptr_q;
  logic [VW-1:0] fifo_mem [2];
  logic [VW-1:0] head;
  logic          accept, issue, pop;
  logic          x_wen_q;
  logic [AW-1:0] x_addr_q;
  logic [DW-1:0] x_data_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Leave RUN once the serializer has issued the final element of the last matrix.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = (i_matrix_num == 5'd0) ? S_DONE : S_RUN;
      S_RUN:   if (wr_mtx_q == num_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_x_rdy     = (state_q == S_RUN) && (fifo_cnt_q < 2'd2) && (acc_cnt_q < num_q);
    o_busy      = (state_q != S_IDLE);
    o_proc_done = (state_q == S_DONE);
  end

  assign accept = i_x_vld && o_x_rdy;
  assign issue  = (state_q == S_RUN) && (fifo_cnt_q != 2'd0);
  assign pop    = issue && (elem_q == EW'(N_ELEM - 1));
  assign head   = fifo_mem[rd_ptr_q];

  always_comb begin
    num_d     = num_q;
    acc_cnt_d = acc_cnt_q;
    wr_mtx_d  = wr_mtx_q;
    elem_d    = elem_q;
    if ((state_q == S_IDLE) && i_start) begin
      num_d     = i_matrix_num;
      acc_cnt_d = '0;
      wr_mtx_d  = '0;
      elem_d    = '0;
    end
    if (accept) acc_cnt_d = acc_cnt_q + 5'd1;
    if (issue) begin
      elem_d = pop ? '0 : elem_q + EW'(1);
      if (pop) wr_mtx_d = wr_mtx_q + 5'd1;
    end
  end

  // A same-cycle push and pop leaves the occupancy untouched.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({accept, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      num_q      <= '0;
      acc_cnt_q  <= '0;
      wr_mtx_q   <= '0;
      elem_q     <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      x_wen_q    <= 1'b0;
      x_addr_q   <= '0;
      x_data_q   <= '0;
    end else begin
      num_q      <= num_d;
      acc_cnt_q  <= acc_cnt_d;
      wr_mtx_q   <= wr_mtx_d;
      elem_q     <= elem_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      x_wen_q <= issue;
      if (issue) begin
        x_addr_q <= AW'(wr_mtx_q) * AW'(N_ELEM) + AW'(elem_q);
        x_data_q <= head[int'(elem_q) * DW +: DW];
      end
    end
  end

  // Vector storage needs no reset: occupancy alone says which slots are live.
  always_ff @(posedge i_clk) begin
    if (accept) fifo_mem[wr_ptr_q] <= i_x_vec;
  end

  assign o_x_wen  = x_wen_q;
  assign o_x_addr = x_addr_q;
  assign o_x_data = x_data_q;

endmodule

// File: tb/tb_gsim_x_writer.sv
// tb/tb_gsim_x_writer.sv - randomized self-checking bench for gsim_x_writer
module tb_gsim_x_writer;

  localparam int NEVER = 32'h7fffffff;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_start = 1'b0;
  logic [4:0]   i_matrix_num = '0;
  logic         i_x_vld = 1'b0;
  logic [511:0] i_x_vec = '0;
  logic         o_x_rdy, o_x_wen, o_busy, o_proc_done;
  logic [8:0]   o_x_addr;
  logic [31:0]  o_x_data;

  gsim_x_writer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_matrix_num(i_matrix_num),
    .i_x_vld(i_x_vld), .i_x_vec(i_x_vec), .o_x_rdy(o_x_rdy), .o_x_wen(o_x_wen),
    .o_x_addr(o_x_addr), .o_x_data(o_x_data), .o_busy(o_busy), .o_proc_done(o_proc_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          avail;
    logic [8:0]  addr;
    logic [31:0] data;
  } word_t;

  word_t pend[$];
  int  checks = 0, failures = 0, cyc = 0;
  bit  job_on = 0, took = 0;
  int  m_num = 0, m_acc = 0, m_wr = 0, done_due = NEVER, acc_edge = 0, start_edge = 0;
  int  dut_nwr = 0, dut_first_wr = 0, dut_last_wr = 0, dut_ndone = 0, dut_done_cyc = 0, dut_nacc = 0;
  logic [8:0]  dut_first_addr = '0, dut_last_addr = '0;
  logic [31:0] dut_last_data = '0;
  bit  prod_en = 0, chg_en = 0;
  int  vld_pct = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_rec();
    dut_nwr = 0; dut_ndone = 0; dut_nacc = 0; dut_done_cyc = -1;
    dut_first_wr = -1; dut_last_wr = -1; dut_first_addr = '0; dut_last_addr = '0; dut_last_data = '0;
  endtask

  always @(posedge i_clk) cyc++;

  // Reference: each accepted vector becomes 16 (addr,data) words written in order, one per
  // cycle, the first no earlier than two edges after acceptance; occupancy = vectors with words left.
  always @(negedge i_clk) begin
    bit ew, eb, ed, er, st;
    if (i_reset) begin
      pend.delete(); job_on = 0; took = 0; m_acc = 0; m_num = 0; m_wr = 0; done_due = NEVER;
    end else begin
      ew = (pend.size() > 0) && (pend[0].avail <= cyc);
      chk("x_wen", o_x_wen, ew);
      if (ew) begin
        chk("x_addr", o_x_addr, pend[0].addr);
        chk("x_data", o_x_data, pend[0].data);
        void'(pend.pop_front());
        m_wr++;
        if (m_wr == m_num * 16) done_due = cyc + 1;
      end
      eb = job_on;
      ed = job_on && (cyc == done_due);
      er = job_on && !ed && ((pend.size() + 15) / 16 < 2) && (m_acc < m_num);
      chk("busy", o_busy, eb);
      chk("proc_done", o_proc_done, ed);
      chk("x_rdy", o_x_rdy, er);
      st   = i_start && !eb;
      took = i_x_vld && er;
      if (ed) job_on = 0;
      if (took) begin
        for (int k = 0; k < 16; k++)
          pend.push_back('{cyc + 2, 9'(m_acc * 16 + k), i_x_vec[32*k +: 32]});
        m_acc++;
        acc_edge = cyc + 1;
      end
      if (st) begin
        job_on = 1; m_num = int'(i_matrix_num); m_acc = 0; m_wr = 0; start_edge = cyc + 1;
        done_due = (i_matrix_num == 5'd0) ? cyc + 1 : NEVER;
      end
      if (o_x_wen) begin
        if (dut_nwr == 0) begin dut_first_wr = cyc; dut_first_addr = o_x_addr; end
        dut_nwr++; dut_last_wr = cyc; dut_last_addr = o_x_addr; dut_last_data = o_x_data;
      end
      if (o_proc_done) begin dut_ndone++; dut_done_cyc = cyc; end
      if (i_x_vld && o_x_rdy) dut_nacc++;
    end
  end

  // Upstream: holds a vector until accepted; optionally rewrites it while it is still waiting.
  always @(posedge i_clk) begin
    #1;
    if (prod_en) begin
      if (!i_x_vld || took) begin
        i_x_vld = ($urandom_range(99) < vld_pct);
        i_x_vec = rand_vec();
      end else if (chg_en) begin
        i_x_vec = rand_vec();
      end
    end
  end

  task automatic wait_job_end();
    int t;
    t = 0;
    while (job_on && t < 4000) begin
      @(posedge i_clk);
      t++;
    end
    chk("job_end", job_on, 0);
  endtask

  task automatic run_job(input int n, input int pct, input bit chg, input bit restart);
    @(posedge i_clk); #1;
    clear_rec();
    i_start = 1'b1; i_matrix_num = 5'(n);
    @(posedge i_clk); #1;
    i_start = 1'b0; vld_pct = pct; chg_en = chg; prod_en = (n != 0);
    if (restart) begin
      repeat (3) @(posedge i_clk);
      #1 i_start = 1'b1; i_matrix_num = 5'd9;
      @(posedge i_clk);
      #1 i_start = 1'b0;
    end
    wait_job_end();
    #2 prod_en = 0; i_x_vld = 1'b0;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_wen", o_x_wen, 0);
    chk("reset_addr", o_x_addr, 0);
    chk("reset_data", o_x_data, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_rdy", o_x_rdy, 0);
    chk("reset_done", o_proc_done, 0);
    i_reset = 1'b0;

    // Valid with no job: must be ignored.
    clear_rec();
    i_x_vld = 1'b1; i_x_vec = rand_vec();
    repeat (6) @(posedge i_clk);
    #1 i_x_vld = 1'b0;
    chk("idle_writes", dut_nwr, 0);
    chk("idle_accepts", dut_nacc, 0);

    // Single matrix with known data.
    clear_rec();
    i_start = 1'b1; i_matrix_num = 5'd1;
    @(posedge i_clk);
    #1 i_start = 1'b0; i_x_vld = 1'b1;
    for (int k = 0; k < 16; k++) i_x_vec[32*k +: 32] = 32'h1000_0000 + k;
    for (t = 0; t < 50; t++) begin
      @(posedge i_clk); #1;
      if (took) break;
    end
    i_x_vld = 1'b0;
    wait_job_end();
    #1;
    chk("single_first_wr", dut_first_wr, acc_edge + 1);
    chk("single_nwr", dut_nwr, 16);
    chk("single_first_addr", dut_first_addr, 0);
    chk("single_last_addr", dut_last_addr, 15);
    chk("single_last_data", dut_last_data, 32'h1000_000F);
    chk("single_done_cyc", dut_done_cyc, dut_last_wr + 1);
    chk("single_ndone", dut_ndone, 1);
    chk("single_busy_after", o_busy, 0);

    // Back-to-back with valid held high.
    run_job(3, 100, 0, 0);
    chk("b2b_accepts", dut_nacc, 3);
    chk("b2b_nwr", dut_nwr, 48);
    chk("b2b_span", dut_last_wr - dut_first_wr, 47);
    chk("b2b_last_addr", dut_last_addr, 47);

    // Random jobs with stalls and changing data; one gets a stray i_start during RUN.
    for (int i = 0; i < 6; i++) begin
      run_job(int'($urandom_range(1, 6)), int'($urandom_range(20, 100)), 1, i == 2);
      chk("rand_ndone", dut_ndone, 1);
    end

    // Largest job.
    run_job(31, 100, 0, 0);
    chk("max_last_addr", dut_last_addr, 495);
    chk("max_nwr", dut_nwr, 496);

    // Empty job.
    run_job(0, 100, 0, 0);
    chk("zero_nwr", dut_nwr, 0);
    chk("zero_ndone", dut_ndone, 1);
    chk("zero_done_cyc", dut_done_cyc, start_edge);

    // Reset in the middle of a two-matrix job.
    @(posedge i_clk); #1;
    clear_rec();
    i_start = 1'b1; i_matrix_num = 5'd2;
    @(posedge i_clk);
    #1 i_start = 1'b0; vld_pct = 100; chg_en = 0; prod_en = 1;
    for (t = 0; t < 200 && dut_nwr < 5; t++) @(negedge i_clk);
    chk("midreset_reached", dut_nwr, 5);
    #1 i_reset = 1'b1; prod_en = 0;
    #1;
    chk("midreset_wen", o_x_wen, 0);
    chk("midreset_addr", o_x_addr, 0);
    chk("midreset_data", o_x_data, 0);
    chk("midreset_busy", o_busy, 0);
    chk("midreset_rdy", o_x_rdy, 0);
    i_x_vld = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    run_job(1, 100, 0, 0);
    chk("post_reset_first_addr", dut_first_addr, 0);
    chk("post_reset_nwr", dut_nwr, 16);
    chk("post_reset_last_addr", dut_last_addr, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
